// File: rtl/msg_bus_bridge.sv
// rtl/msg_bus_bridge.sv - bus-beat to message packer/unpacker bridge
module msg_bus_bridge #(
    parameter int BUS_W = 32,
    parameter int MSG_W = 128,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             write_enq_ena,
    input  logic [BUS_W-1:0] write_enq_v,
    input  logic [LEN_W-1:0] write_enq_length,
    output logic             write_enq_rdy,
    output logic             request_enq_ena,
    output logic [MSG_W-1:0] request_enq_v,
    output logic [LEN_W-1:0] request_enq_length,
    input  logic             request_enq_rdy,
    input  logic             indication_enq_ena,
    input  logic [MSG_W-1:0] indication_enq_v,
    output logic             indication_enq_rdy,
    output logic             read_enq_ena,
    output logic [BUS_W-1:0] read_enq_v,
    output logic [LEN_W-1:0] read_enq_length,
    input  logic             read_enq_rdy,
    output logic             len_err,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] ind_count
);

    localparam int BEATS = MSG_W / BUS_W;

    typedef enum logic [1:0] {W_IDLE, W_ACC, W_EMIT} w_state_t;
    typedef enum logic       {R_IDLE, R_SEND}        r_state_t;

    w_state_t         w_state, w_next;
    r_state_t         r_state, r_next;
    logic [MSG_W-1:0] w_buf, r_buf;
    logic [LEN_W-1:0] w_len, w_idx, r_len, r_idx;
    logic [BUS_W-1:0] r_slot;
    logic [LEN_W-1:0] w_hdr, r_hdr;
    logic             w_take, r_take, r_give;

    logic unused_len;
    assign unused_len = ^write_enq_length;

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] raw);
        if (raw == '0)                 return LEN_W'(1);
        else if (raw > LEN_W'(BEATS))  return LEN_W'(BEATS);
        else                           return raw;
    endfunction

    assign w_hdr  = write_enq_v[LEN_W-1:0];
    assign r_hdr  = indication_enq_v[LEN_W-1:0];
    assign w_take = write_enq_ena && write_enq_rdy;
    assign r_take = indication_enq_ena && indication_enq_rdy;
    assign r_give = read_enq_ena && read_enq_rdy;

    always_comb begin
        w_next             = w_state;
        write_enq_rdy      = 1'b1;
        request_enq_ena    = 1'b0;
        request_enq_v      = '0;
        request_enq_length = '0;
        case (w_state)
            W_IDLE: if (w_take) w_next = (eff_len(w_hdr) == LEN_W'(1)) ? W_EMIT : W_ACC;
            W_ACC:  if (w_take && (w_idx == w_len - LEN_W'(1))) w_next = W_EMIT;
            W_EMIT: begin
                write_enq_rdy      = 1'b0;
                request_enq_ena    = 1'b1;
                request_enq_v      = w_buf;
                request_enq_length = w_len;
                if (request_enq_rdy) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            w_state   <= W_IDLE;
            w_buf     <= '0;
            w_len     <= '0;
            w_idx     <= '0;
            req_count <= '0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: if (w_take) begin
                    w_buf <= MSG_W'(write_enq_v);
                    w_len <= eff_len(w_hdr);
                    w_idx <= LEN_W'(1);
                end
                W_ACC: if (w_take) begin
                    for (int s = 1; s < BEATS; s++)
                        if (w_idx == LEN_W'(s)) w_buf[s*BUS_W +: BUS_W] <= write_enq_v;
                    w_idx <= w_idx + LEN_W'(1);
                end
                W_EMIT: if (request_enq_rdy) req_count <= req_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        r_slot = '0;
        for (int s = 0; s < BEATS; s++)
            if (r_idx == LEN_W'(s)) r_slot = r_buf[s*BUS_W +: BUS_W];
    end

    always_comb begin
        r_next             = r_state;
        indication_enq_rdy = 1'b0;
        read_enq_ena       = 1'b0;
        read_enq_v         = '0;
        read_enq_length    = '0;
        case (r_state)
            R_IDLE: begin
                indication_enq_rdy = 1'b1;
                if (r_take) r_next = R_SEND;
            end
            R_SEND: begin
                read_enq_ena    = 1'b1;
                read_enq_v      = r_slot;
                read_enq_length = r_len - r_idx;
                if (read_enq_rdy && (r_idx == r_len - LEN_W'(1))) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= R_IDLE;
            r_buf     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            ind_count <= '0;
        end else begin
            r_state <= r_next;
            if (r_take) begin
                r_buf <= indication_enq_v;
                r_len <= eff_len(r_hdr);
                r_idx <= '0;
            end else if (r_give) begin
                r_idx <= r_idx + LEN_W'(1);
                if (r_idx == r_len - LEN_W'(1)) ind_count <= ind_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            len_err <= 1'b0;
        end else if ((w_state == W_IDLE && w_take && w_hdr > LEN_W'(BEATS)) ||
                     (r_take && r_hdr > LEN_W'(BEATS))) begin
            len_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_msg_bus_bridge.sv
// tb/tb_msg_bus_bridge.sv - directed self-checking bench for msg_bus_bridge
module tb_msg_bus_bridge;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         write_ena;
    logic [31:0]  write_v;
    logic [15:0]  write_len;
    logic         write_rdy;
    logic         req_ena;
    logic [127:0] req_v;
    logic [15:0]  req_len;
    logic         req_rdy;
    logic         ind_ena;
    logic [127:0] ind_v;
    logic         ind_rdy;
    logic         read_ena;
    logic [31:0]  read_v;
    logic [15:0]  read_len;
    logic         read_rdy;
    logic         len_err;
    logic [31:0]  req_count;
    logic [31:0]  ind_count;

    int tests = 0;
    int fails = 0;

    msg_bus_bridge dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .write_enq_ena      (write_ena),
        .write_enq_v        (write_v),
        .write_enq_length   (write_len),
        .write_enq_rdy      (write_rdy),
        .request_enq_ena    (req_ena),
        .request_enq_v      (req_v),
        .request_enq_length (req_len),
        .request_enq_rdy    (req_rdy),
        .indication_enq_ena (ind_ena),
        .indication_enq_v   (ind_v),
        .indication_enq_rdy (ind_rdy),
        .read_enq_ena       (read_ena),
        .read_enq_v         (read_v),
        .read_enq_length    (read_len),
        .read_enq_rdy       (read_rdy),
        .len_err            (len_err),
        .req_count          (req_count),
        .ind_count          (ind_count)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        write_ena = 1'b1;
        write_v   = d;
        while (!write_rdy && n < 50) begin
            step();
            n++;
        end
        if (!write_rdy) begin
            tests++;
            fails++;
            $display("FAIL write_rdy_timeout: got %b want 1", write_rdy);
        end
        step();
        write_ena = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; write_ena = 0; write_v = 0; write_len = 16'hFFFF; req_rdy = 0;
        ind_ena = 0; ind_v = 0; read_rdy = 0;
        step();
        nRST = 1'b1;
        tests++; if (write_rdy !== 1'b1) begin fails++; $display("FAIL reset_write_rdy: got %b want 1", write_rdy); end
        tests++; if (ind_rdy !== 1'b1) begin fails++; $display("FAIL reset_ind_rdy: got %b want 1", ind_rdy); end
        tests++; if (req_ena !== 1'b0 || req_v !== '0 || req_len !== '0) begin fails++; $display("FAIL reset_req: got ena=%b v=%h len=%0d want 0", req_ena, req_v, req_len); end
        tests++; if (read_ena !== 1'b0 || read_v !== '0 || read_len !== '0) begin fails++; $display("FAIL reset_read: got ena=%b v=%h len=%0d want 0", read_ena, read_v, read_len); end
        tests++; if (req_count !== 0 || ind_count !== 0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", req_count, ind_count); end
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    endtask

    task automatic test_write4;
        req_rdy = 1'b1;
        send_beat(32'h4); send_beat(32'hA); send_beat(32'hB); send_beat(32'hC);
        tests++; if (req_ena !== 1'b1) begin fails++; $display("FAIL w4_ena_latency: got %b want 1", req_ena); end
        tests++; if (req_v !== 128'h0000000C_0000000B_0000000A_00000004) begin fails++; $display("FAIL w4_v: got %h want 0000000c0000000b0000000a00000004", req_v); end
        tests++; if (req_len !== 16'd4) begin fails++; $display("FAIL w4_len: got %0d want 4", req_len); end
        tests++; if (write_rdy !== 1'b0) begin fails++; $display("FAIL w4_wrdy_emit: got %b want 0", write_rdy); end
        step();
        tests++; if (req_ena !== 1'b0) begin fails++; $display("FAIL w4_ena_after: got %b want 0", req_ena); end
        tests++; if (req_count !== 32'd1) begin fails++; $display("FAIL w4_count: got %0d want 1", req_count); end
    endtask

    task automatic test_backpressure;
        req_rdy = 1'b0;
        send_beat(32'h2); send_beat(32'h55);
        for (int c = 0; c < 5; c++) begin
            tests++; if (write_rdy !== 1'b0 || req_ena !== 1'b1) begin fails++; $display("FAIL bp_hold_%0d: got wrdy=%b ena=%b want 0/1", c, write_rdy, req_ena); end
            tests++; if (req_v !== 128'h00000055_00000002 || req_len !== 16'd2) begin fails++; $display("FAIL bp_data_%0d: got v=%h len=%0d want 5500000002/2", c, req_v, req_len); end
            step();
        end
        req_rdy = 1'b1;
        step();
        tests++; if (req_count !== 32'd2 || req_ena !== 1'b0) begin fails++; $display("FAIL bp_done: got count=%0d ena=%b want 2/0", req_count, req_ena); end
    endtask

    task automatic test_read;
        logic [31:0] exp_v [3];
        logic [15:0] exp_l [3];
        exp_v[0] = 32'h3;  exp_v[1] = 32'h11; exp_v[2] = 32'h22;
        exp_l[0] = 16'd3;  exp_l[1] = 16'd2;  exp_l[2] = 16'd1;
        read_rdy = 1'b0;
        ind_v    = 128'h00000000_00000022_00000011_00000003;
        ind_ena  = 1'b1;
        step();
        ind_ena  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (read_ena !== 1'b1 || read_v !== exp_v[k] || read_len !== exp_l[k]) begin fails++; $display("FAIL rd_beat_%0d: got ena=%b v=%h len=%0d want 1/%h/%0d", k, read_ena, read_v, read_len, exp_v[k], exp_l[k]); end
            tests++; if (ind_rdy !== 1'b0) begin fails++; $display("FAIL rd_ind_rdy_%0d: got %b want 0", k, ind_rdy); end
            step();
            tests++; if (read_v !== exp_v[k] || read_len !== exp_l[k]) begin fails++; $display("FAIL rd_hold_%0d: got v=%h len=%0d want %h/%0d", k, read_v, read_len, exp_v[k], exp_l[k]); end
            read_rdy = 1'b1;
            step();
            read_rdy = 1'b0;
        end
        tests++; if (read_ena !== 1'b0 || ind_rdy !== 1'b1) begin fails++; $display("FAIL rd_end: got ena=%b ind_rdy=%b want 0/1", read_ena, ind_rdy); end
        tests++; if (ind_count !== 32'd1) begin fails++; $display("FAIL rd_count: got %0d want 1", ind_count); end
    endtask

    task automatic test_len_clamp;
        req_rdy = 1'b1;
        send_beat(32'h0);
        tests++; if (req_ena !== 1'b1 || req_len !== 16'd1 || req_v !== '0) begin fails++; $display("FAIL l0_req: got ena=%b len=%0d v=%h want 1/1/0", req_ena, req_len, req_v); end
        step();
        tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL l0_len_err: got %b want 0", len_err); end
        send_beat(32'h9); send_beat(32'h1); send_beat(32'h2); send_beat(32'h3);
        tests++; if (req_ena !== 1'b1 || req_len !== 16'd4) begin fails++; $display("FAIL l9_req: got ena=%b len=%0d want 1/4", req_ena, req_len); end
        tests++; if (req_v !== 128'h00000003_00000002_00000001_00000009) begin fails++; $display("FAIL l9_v: got %h want 00000003000000020000000100000009", req_v); end
        step();
        tests++; if (len_err !== 1'b1) begin fails++; $display("FAIL l9_len_err: got %b want 1", len_err); end
        tests++; if (req_count !== 32'd4) begin fails++; $display("FAIL l9_count: got %0d want 4", req_count); end
    endtask

    task automatic test_reset_mid;
        req_rdy = 1'b1;
        send_beat(32'h4); send_beat(32'hDD);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        tests++; if (req_count !== 0 || len_err !== 1'b0 || write_rdy !== 1'b1) begin fails++; $display("FAIL rm_reset: got count=%0d err=%b wrdy=%b want 0/0/1", req_count, len_err, write_rdy); end
        for (int c = 0; c < 3; c++) begin
            tests++; if (req_ena !== 1'b0) begin fails++; $display("FAIL rm_no_req_%0d: got %b want 0", c, req_ena); end
            step();
        end
        send_beat(32'h2); send_beat(32'h77);
        tests++; if (req_ena !== 1'b1 || req_len !== 16'd2 || req_v !== 128'h00000077_00000002) begin fails++; $display("FAIL rm_next: got ena=%b len=%0d v=%h want 1/2/7700000002", req_ena, req_len, req_v); end
        step();
        tests++; if (req_count !== 32'd1) begin fails++; $display("FAIL rm_count: got %0d want 1", req_count); end
    endtask

    initial begin
        test_reset();
        test_write4();
        test_backpressure();
        test_read();
        test_len_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
